shift_load_arbiter: RTL
=======================

SHIFT_LOAD_ARBITER -- requirements
Module: shift_load_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the serial-load register.
REQ-002 Parameter WIDTH, default 8, bits per transaction, equal to the shared register width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 Port: req  input  NREQ  per-requester load request, level.
REQ-006 Port: data  input  NREQ*WIDTH  per-requester byte; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port: gnt  output  NREQ  one-hot grant, held for the whole transaction.
REQ-008 Port: done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-009 Port: sr_clr  output  1  synchronous clear strobe to the shared register.
REQ-010 Port: sr_wr  output  1  shift-enable to the shared register.
REQ-011 Port: sr_di  output  1  serial data bit to the shared register.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, CLR, SHIFT and ACK.
REQ-014 IDLE: if any req bit is 1, select the winner round-robin, searching upward from (ptr+1) mod NREQ, and go to CLR; otherwise stay in IDLE.
REQ-015 On the selection edge, the winner's data slice SHALL be captured into a WIDTH-bit shadow register, its index latched, and ptr set to the winner index.
REQ-016 CLR: one cycle; sr_clr=1, sr_wr=0; next state SHIFT with bit counter=0.
REQ-017 SHIFT: WIDTH cycles; sr_wr=1, sr_di=shadow[WIDTH-1-cnt] (MSB first); counter increments each cycle; after cnt=WIDTH-1, go to ACK.
REQ-018 ACK: one cycle; done[winner]=1; next state IDLE.
REQ-019 gnt[winner] SHALL be 1 in CLR, SHIFT and ACK, and 0 in IDLE; at most one gnt bit is ever high.
REQ-020 sr_clr, sr_wr and sr_di SHALL be 0 in every state other than the one driving them.
REQ-021 All outputs SHALL be registered, or decoded from registered state only; no combinational path from req/data to any output.
REQ-022 Latency: req first sampled high at edge T gives gnt at T+1, first sr_wr at T+2, done at T+2+WIDTH, and IDLE again at T+3+WIDTH.
REQ-023 If req is deasserted or data changes mid-transaction, the transaction SHALL complete unchanged using the shadow data.
REQ-024 A requester still holding req in ACK SHALL re-arbitrate normally in the following IDLE cycle; fairness comes from ptr alone.
REQ-025 Simultaneous requests SHALL be serviced one per transaction in round-robin order, with no requester starved.
REQ-026 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-027 When rst=0: state=IDLE, gnt=0, done=0, sr_clr=0, sr_wr=0, sr_di=0, busy=0, counter=0, shadow=0, and ptr=NREQ-1 (requester 0 has first priority), applied immediately and asynchronously.
REQ-028 Reset asserted mid-transaction SHALL abort it with no done pulse; the first request after deassertion restarts from CLR.

Structure
REQ-029 The state enum (IDLE, CLR, SHIFT, ACK) and default WIDTH/NREQ constants SHALL live in shared package shift_load_pkg.
REQ-030 The round-robin selection SHALL be one combinational sub-module rr_pick (inputs req, ptr; outputs valid, index).

Verification
REQ-031 Single request: req=4'b0010, data[15:8]=8'hA5 -> gnt=4'b0010 for 10 cycles; sr_clr for 1 cycle; sr_di stream 1,0,1,0,0,1,0,1; done[1] pulse at T+10.
REQ-032 All four requesting continuously after reset -> grant order 0,1,2,3,0; each gnt high exactly 10 cycles; one idle cycle between transactions.
REQ-033 req[2] dropped and data[23:16] changed from 8'h3C to 8'hFF during SHIFT -> stream still 0,0,1,1,1,1,0,0; done[2] still pulses.
REQ-034 rst=0 asserted during the 4th SHIFT cycle -> all outputs 0 in the same cycle; no done; next req=4'b0001 gives the full sequence from CLR.
REQ-035 ptr=1 with req=4'b1001 -> requester 3 wins before requester 0.
REQ-036 Assertion check throughout: gnt one-hot-or-zero; sr_wr count between CLR and ACK equals WIDTH.

Source files
------------

// File: rtl/shift_load_arbiter_pkg.sv
// Shared types and default sizing for the shift-load arbiter slice.
// The FSM state encoding lives here so the top, the interface and benches agree on it.
package shift_load_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

    // Index width that stays legal for degenerate sizes of 1.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_load_arbiter_if.sv
// Request/grant and shared-register bus between the requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface shift_load_arbiter_if
    import shift_load_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  sr_clr;
    logic                  sr_wr;
    logic                  sr_di;
    logic                  busy;

    modport master (
        output req, data,
        input  gnt, done, sr_clr, sr_wr, sr_di, busy
    );

    modport slave (
        input  req, data,
        output gnt, done, sr_clr, sr_wr, sr_di, busy
    );
endinterface

// File: rtl/shift_load_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester found searching upward from ptr+1.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   index
);
    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end
endmodule

// File: rtl/shift_load_arbiter.sv
// Arbitrates NREQ requesters onto one serially loaded register: clear, shift WIDTH bits MSB first, ack.
// Every output is decoded from registered state only.
module shift_load_arbiter
    import shift_load_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    shift_load_arbiter_if.slave bus
);
    localparam int IW = idx_bits(NREQ);
    localparam int CW = idx_bits(WIDTH);

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  shadow_reg;
    logic [IW-1:0]     winner_reg;
    logic [IW-1:0]     ptr_reg;
    logic [CW-1:0]     cnt_reg;

    logic              pick_valid;
    logic [IW-1:0]     pick_index;
    logic [WIDTH-1:0]  slice [NREQ];
    logic              cnt_last;
    logic [CW-1:0]     bit_idx;
    logic              busy_c;
    logic              ack_c;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign slice[gi] = bus.data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .index (pick_index)
    );

    assign cnt_last = (cnt_reg == CW'(WIDTH - 1));
    assign bit_idx  = CW'(WIDTH - 1) - cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_valid) state_next = CLR;
            CLR:     state_next = SHIFT;
            SHIFT:   if (cnt_last) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shadow copy decouples the transaction from req/data changes after selection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_reg <= '0;
            winner_reg <= '0;
            ptr_reg    <= IW'(NREQ - 1);
            cnt_reg    <= '0;
        end else begin
            if (state_reg == IDLE && pick_valid) begin
                shadow_reg <= slice[pick_index];
                winner_reg <= pick_index;
                ptr_reg    <= pick_index;
            end
            if (state_reg == CLR)
                cnt_reg <= '0;
            else if (state_reg == SHIFT)
                cnt_reg <= cnt_last ? '0 : cnt_reg + 1'b1;
        end
    end

    always_comb begin
        bus.sr_clr = 1'b0;
        bus.sr_wr  = 1'b0;
        bus.sr_di  = 1'b0;
        busy_c     = 1'b1;
        ack_c      = 1'b0;
        case (state_reg)
            IDLE:  busy_c = 1'b0;
            CLR:   bus.sr_clr = 1'b1;
            SHIFT: begin
                bus.sr_wr = 1'b1;
                bus.sr_di = shadow_reg[bit_idx];
            end
            ACK:   ack_c = 1'b1;
            default: busy_c = 1'b0;
        endcase
    end

    assign bus.busy = busy_c;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_grant
            assign bus.gnt[gi]  = busy_c && (winner_reg == IW'(gi));
            assign bus.done[gi] = ack_c  && (winner_reg == IW'(gi));
        end
    endgenerate
endmodule
